fpu_exec_seq: RTL and testbench

- Execute-stage sequencer for single-precision FP instructions; consumes the 5-bit operation select from the FPU decode stage plus operands.
- Performs min/max/compare/move ops directly and cvt.s.w by iterative normalisation.
- Hands add/sub/mul to an external arithmetic core over a start/done handshake.
- Drives pipeline stall (busy), a done pulse, the result, and the destination register-file write enables.

---
 rtl/fpu_exec_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_fpu_exec_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exec_seq.sv
// fpu_exec_seq: execute-stage sequencer for single-precision FP instructions.
//
// Takes the 5-bit op select from the FPU decode stage plus operands and
// produces a result with register-file write enables.
//   - min/max/eq/lt/le and the two raw moves complete in one cycle.
//   - add/sub/mul are handed to an external arithmetic core.
//   - cvt.s.w normalises iteratively, one bit per cycle.
//
// Op select: 4 add, 5 sub, 6 mul, 7 min, 8 max, 9 eq, 10 lt, 11 le,
//            12 mv int->fp, 13 mv fp->int, 14 cvt.s.w, anything else illegal.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, sel        issue request and op select (sampled only when idle)
//   rs1_int           integer source for ops 12 and 14
//   fs1, fs2          FP sources
//   busy              stall request, high whenever the sequencer is not idle
//   done              one-cycle pulse; result/wr_fp/wr_int/illegal valid
//   result            operation result, held between done pulses
//   wr_fp, wr_int     destination regfile write enables (with done)
//   illegal           unsupported op select (with done)
//   arith_start       one-cycle pulse to the arithmetic core
//   arith_op          0 add, 1 sub, 2 mul; held while waiting
//   arith_a, arith_b  operands latched at issue, held while waiting
//   arith_done        core result valid
//   arith_result      core result
//   dbg_state         current FSM state, for observation only
//
// Configuration macro: FPU_CVT_RNE_EN
//   defined   -> cvt.s.w rounds to nearest-even in the pack cycle
//   undefined -> cvt.s.w truncates toward zero
//
// Handshakes:
//   Issue: a request is accepted on a rising edge where start=1 and busy=0;
//   start while busy is dropped, not queued. Completion is the single-cycle
//   done pulse; a start in the done cycle is accepted (busy is already 0).
//   Core: arith_start pulses in the first ARITH_WAIT cycle; arith_done is
//   sampled on every ARITH_WAIT edge, including the arith_start cycle, and
//   is ignored in any other state.

module fpu_exec_seq #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  sel,
  input  logic [31:0] rs1_int,
  input  logic [31:0] fs1,
  input  logic [31:0] fs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        wr_fp,
  output logic        wr_int,
  output logic        illegal,
  output logic        arith_start,
  output logic [1:0]  arith_op,
  output logic [31:0] arith_a,
  output logic [31:0] arith_b,
  input  logic        arith_done,
  input  logic [31:0] arith_result,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ARITH_WAIT = 2'd1;
  localparam logic [1:0] CVT_NORM   = 2'd2;

  // Op classes decoded from sel
  localparam logic [1:0] K_SINGLE = 2'd0;
  localparam logic [1:0] K_ARITH  = 2'd1;
  localparam logic [1:0] K_CVT    = 2'd2;

  logic [1:0]  state;
  logic        cvt_sign;
  logic [31:0] cvt_mag;   // normalisation shift register
  logic [4:0]  cvt_cnt;   // number of left shifts so far

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Operand classification and ordering for min/max/compare
  // ---------------------------------------------------------------------
  logic nan1, nan2, both_zero, lt_tot;

  assign nan1      = (fs1[30:23] == 8'hFF) && (fs1[22:0] != 23'd0);
  assign nan2      = (fs2[30:23] == 8'hFF) && (fs2[22:0] != 23'd0);
  assign both_zero = (fs1[30:0] == 31'd0) && (fs2[30:0] == 31'd0);

  // Sign-magnitude total order on non-NaN values where -0 sorts below +0.
  // Compares undo the zero ordering via both_zero.
  always_comb begin
    lt_tot = 1'b0;
    if (fs1[31] != fs2[31])
      lt_tot = fs1[31];
    else if (!fs1[31])
      lt_tot = (fs1[30:0] < fs2[30:0]);
    else
      lt_tot = (fs1[30:0] > fs2[30:0]);
  end

  logic [31:0] min_val, max_val;
  logic        feq, flt, fle;

  always_comb begin
    min_val = lt_tot ? fs1 : fs2;
    max_val = lt_tot ? fs2 : fs1;
    if (nan1 && nan2) begin
      min_val = CANON_NAN;
      max_val = CANON_NAN;
    end else if (nan1) begin
      min_val = fs2;
      max_val = fs2;
    end else if (nan2) begin
      min_val = fs1;
      max_val = fs1;
    end
  end

  assign feq = !(nan1 || nan2) && ((fs1 == fs2) || both_zero);
  assign flt = !(nan1 || nan2) && !both_zero && lt_tot;
  assign fle = feq || flt;

  // ---------------------------------------------------------------------
  // Issue decode: class, and the complete outcome of single-cycle ops
  // ---------------------------------------------------------------------
  logic [1:0]  kind;
  logic [31:0] sc_result;
  logic        sc_wr_fp, sc_wr_int, sc_illegal;

  always_comb begin
    kind       = K_SINGLE;
    sc_result  = 32'd0;
    sc_wr_fp   = 1'b0;
    sc_wr_int  = 1'b0;
    sc_illegal = 1'b0;
    case (sel)
      5'd4, 5'd5, 5'd6: kind = K_ARITH;
      5'd14:            kind = K_CVT;
      5'd7:  begin sc_result = min_val;           sc_wr_fp  = 1'b1; end
      5'd8:  begin sc_result = max_val;           sc_wr_fp  = 1'b1; end
      5'd9:  begin sc_result = {31'd0, feq};      sc_wr_int = 1'b1; end
      5'd10: begin sc_result = {31'd0, flt};      sc_wr_int = 1'b1; end
      5'd11: begin sc_result = {31'd0, fle};      sc_wr_int = 1'b1; end
      5'd12: begin sc_result = rs1_int;           sc_wr_fp  = 1'b1; end
      5'd13: begin sc_result = fs1;               sc_wr_int = 1'b1; end
      default: sc_illegal = 1'b1;
    endcase
  end

  // Magnitude of the integer source; 0x80000000 negates to itself, which
  // is exactly 2^31 when read as unsigned.
  logic [31:0] int_mag;
  assign int_mag = rs1_int[31] ? (~rs1_int + 32'd1) : rs1_int;

  // ---------------------------------------------------------------------
  // cvt.s.w pack, valid once cvt_mag[31] is set
  // ---------------------------------------------------------------------
  logic [7:0]  pk_exp;
  logic [22:0] pk_mant;
  logic [31:0] cvt_packed;

`ifdef FPU_CVT_RNE_EN
  logic round_up;
  assign round_up = cvt_mag[7] && ((|cvt_mag[6:0]) || cvt_mag[8]);

  always_comb begin
    pk_exp  = 8'd158 - {3'b000, cvt_cnt};
    pk_mant = cvt_mag[30:8];
    if (round_up) begin
      if (&cvt_mag[30:8]) begin
        // Mantissa overflow: 1.111..1 rounds to 10.000..0
        pk_mant = 23'd0;
        pk_exp  = pk_exp + 8'd1;
      end else begin
        pk_mant = cvt_mag[30:8] + 23'd1;
      end
    end
  end
`else
  // Truncation discards the bits below the mantissa.
  logic unused_cvt_low;
  assign unused_cvt_low = ^cvt_mag[7:0];

  always_comb begin
    pk_exp  = 8'd158 - {3'b000, cvt_cnt};
    pk_mant = cvt_mag[30:8];
  end
`endif

  assign cvt_packed = {cvt_sign, pk_exp, pk_mant};

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      result      <= 32'd0;
      wr_fp       <= 1'b0;
      wr_int      <= 1'b0;
      illegal     <= 1'b0;
      arith_start <= 1'b0;
      arith_op    <= 2'd0;
      arith_a     <= 32'd0;
      arith_b     <= 32'd0;
      cvt_sign    <= 1'b0;
      cvt_mag     <= 32'd0;
      cvt_cnt     <= 5'd0;
    end else begin
      // Completion flags are pulses unless re-asserted below.
      done        <= 1'b0;
      wr_fp       <= 1'b0;
      wr_int      <= 1'b0;
      illegal     <= 1'b0;
      arith_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            case (kind)
              K_ARITH: begin
                state       <= ARITH_WAIT;
                arith_start <= 1'b1;
                // sel 4/5/6 map onto core ops 0/1/2 via their low bits
                arith_op    <= sel[1:0];
                arith_a     <= fs1;
                arith_b     <= fs2;
              end
              K_CVT: begin
                if (rs1_int == 32'd0) begin
                  result <= 32'd0;
                  done   <= 1'b1;
                  wr_fp  <= 1'b1;
                end else begin
                  state    <= CVT_NORM;
                  cvt_sign <= rs1_int[31];
                  cvt_mag  <= int_mag;
                  cvt_cnt  <= 5'd0;
                end
              end
              default: begin
                result  <= sc_result;
                done    <= 1'b1;
                wr_fp   <= sc_wr_fp;
                wr_int  <= sc_wr_int;
                illegal <= sc_illegal;
              end
            endcase
          end
        end

        ARITH_WAIT: begin
          if (arith_done) begin
            result <= arith_result;
            done   <= 1'b1;
            wr_fp  <= 1'b1;
            state  <= IDLE;
          end
        end

        CVT_NORM: begin
          if (!cvt_mag[31]) begin
            cvt_mag <= {cvt_mag[30:0], 1'b0};
            cvt_cnt <= cvt_cnt + 5'd1;
          end else begin
            result <= cvt_packed;
            done   <= 1'b1;
            wr_fp  <= 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_exec_seq.sv
// Self-checking bench for fpu_exec_seq: a directed vector table, hand-written
// multi-cycle sequences, and randomized issue checked against a value-level
// model of the op semantics. Inputs change and outputs are sampled on the
// falling clock edge.

module tb_fpu_exec_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  sel;
  logic [31:0] rs1_int, fs1, fs2;
  logic        busy, done, wr_fp, wr_int, illegal, arith_start;
  logic [31:0] result, arith_a, arith_b;
  logic [1:0]  arith_op, dbg_state;
  logic        arith_done;
  logic [31:0] arith_result;

  always #5 clk = ~clk;

  fpu_exec_seq dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .rs1_int(rs1_int),
    .fs1(fs1), .fs2(fs2), .busy(busy), .done(done), .result(result),
    .wr_fp(wr_fp), .wr_int(wr_int), .illegal(illegal),
    .arith_start(arith_start), .arith_op(arith_op), .arith_a(arith_a),
    .arith_b(arith_b), .arith_done(arith_done), .arith_result(arith_result),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- arithmetic core responder ----------------
  int          arith_delay = 0;
  logic [31:0] arith_resp = 32'd0;
  logic        force_late = 1'b0;
  int          n_arith_start = 0;
  logic [1:0]  cap_op;
  logic [31:0] cap_a, cap_b;

  initial begin
    bit pend;
    int cd;
    pend = 0;
    cd = 0;
    arith_done = 1'b0;
    arith_result = 32'd0;
    forever begin
      @(negedge clk);
      arith_done = force_late;
      if (reset) pend = 0;
      else begin
        if (arith_start) begin
          pend = 1;
          cd = arith_delay;
          n_arith_start++;
          cap_op = arith_op;
          cap_a = arith_a;
          cap_b = arith_b;
        end
        if (pend) begin
          if (cd == 0) begin
            arith_done = 1'b1;
            arith_result = arith_resp;
            pend = 0;
          end else cd--;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  localparam logic [31:0] CANON = 32'h7FC00000;

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signed numeric key: ordering of non-NaN floats equals ordering of keys;
  // +0 and -0 share key 0.
  function automatic longint m_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] m_minmax(input bit is_max, input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if (m_nan(a) && m_nan(b)) return CANON;
    if (m_nan(a)) return b;
    if (m_nan(b)) return a;
    ka = m_key(a);
    kb = m_key(b);
    if (ka < kb) return is_max ? b : a;
    if (kb < ka) return is_max ? a : b;
    if (is_max) return a[31] ? b : a;
    return a[31] ? a : b;
  endfunction

  task automatic m_cvt(input logic [31:0] r, output logic [31:0] res, output int lat);
    longint v, mag, m;
    int p, sh;
    logic s;
    logic [7:0] e;
    if (r == 32'd0) begin
      res = 32'd0;
      lat = 1;
      return;
    end
    v = r[31] ? (longint'(r) - (longint'(1) << 32)) : longint'(r);
    s = (v < 0);
    mag = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 1) == 1) p = i;
    e = 8'(127 + p);
    if (p <= 23) m = mag << (23 - p);
    else begin
      sh = p - 23;
      m = mag >> sh;
`ifdef FPU_CVT_RNE_EN
      begin
        longint rem, half;
        rem = mag - (m << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (m & 1) == 1)) m = m + 1;
        if (m == (longint'(1) << 24)) begin
          m = longint'(1) << 23;
          e = e + 8'd1;
        end
      end
`endif
    end
    res = {s, e, m[22:0]};
    lat = 33 - p;
  endtask

  task automatic model(input logic [4:0] s, input logic [31:0] r, input logic [31:0] a,
                       input logic [31:0] b, input int d, input logic [31:0] resp,
                       output logic [31:0] res, output logic fp, output logic wi,
                       output logic ill, output int lat);
    bit anynan;
    anynan = m_nan(a) || m_nan(b);
    res = 32'd0; fp = 0; wi = 0; ill = 0; lat = 1;
    case (s)
      5'd4, 5'd5, 5'd6: begin res = resp; fp = 1; lat = d + 2; end
      5'd7:  begin res = m_minmax(0, a, b); fp = 1; end
      5'd8:  begin res = m_minmax(1, a, b); fp = 1; end
      5'd9:  begin res = {31'd0, !anynan && (m_key(a) == m_key(b))}; wi = 1; end
      5'd10: begin res = {31'd0, !anynan && (m_key(a) <  m_key(b))}; wi = 1; end
      5'd11: begin res = {31'd0, !anynan && (m_key(a) <= m_key(b))}; wi = 1; end
      5'd12: begin res = r; fp = 1; end
      5'd13: begin res = a; wi = 1; end
      5'd14: begin m_cvt(r, res, lat); fp = 1; end
      default: ill = 1;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the falling edge where done
  // is seen, so consecutive calls issue back-to-back in the done cycle.
  task automatic issue(input logic [4:0] s, input logic [31:0] r, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic fp,
                       output logic wi, output logic ill, output int lat);
    start = 1'b1; sel = s; rs1_int = r; fs1 = a; fs2 = b;
    @(negedge clk);
    start = 1'b0;
    // Scramble operands so that anything not latched at issue shows up.
    sel = 5'($urandom); rs1_int = $urandom; fs1 = $urandom; fs2 = $urandom;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout sel=%0d: no done after %0d cycles, expected done", s, lat);
    end
    res = result; fp = wr_fp; wi = wr_int; ill = illegal;
  endtask

  task automatic run_check(input string tag, input logic [4:0] s, input logic [31:0] r,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_res, input logic e_fp, input logic e_wi,
                           input logic e_ill, input int e_lat);
    logic [31:0] res, q;
    logic fp, wi, ill;
    int lat;
    exp_q.push_back(e_res);
    issue(s, r, a, b, res, fp, wi, ill, lat);
    q = exp_q.pop_front();
    chk({tag, " result"}, res, q);
    chk({tag, " wr_fp"}, 32'(fp), 32'(e_fp));
    chk({tag, " wr_int"}, 32'(wi), 32'(e_wi));
    chk({tag, " illegal"}, 32'(ill), 32'(e_ill));
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]  sel;
    logic [31:0] rs1, a, b, res;
    logic        fp, wi, ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

`ifdef FPU_CVT_RNE_EN
  localparam logic [31:0] CVT_0103 = 32'h4B800002;
`else
  localparam logic [31:0] CVT_0103 = 32'h4B800001;
`endif

  initial begin
    logic [31:0] res;
    logic fp, wi, ill, seen;
    int lat, n0, bad_busy, d;
    logic [4:0] s;
    logic [31:0] r, a, b, resp, e_res;
    logic e_fp, e_wi, e_ill;
    int e_lat;

    vt.push_back('{5'd7,  0, 32'h7FC00000, 32'hBF800000, 32'hBF800000, 1, 0, 0, 1});
    vt.push_back('{5'd7,  0, 32'h00000000, 32'h80000000, 32'h80000000, 1, 0, 0, 1});
    vt.push_back('{5'd8,  0, 32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 0, 1});
    vt.push_back('{5'd8,  0, 32'h7FC00000, 32'hFF800001, 32'h7FC00000, 1, 0, 0, 1});
    vt.push_back('{5'd10, 0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 0, 1, 0, 1});
    vt.push_back('{5'd10, 0, 32'hBF800000, 32'h3F800000, 32'h00000001, 0, 1, 0, 1});
    vt.push_back('{5'd10, 0, 32'hC0000000, 32'hBF800000, 32'h00000001, 0, 1, 0, 1});
    vt.push_back('{5'd10, 0, 32'h80000000, 32'h00000000, 32'h00000000, 0, 1, 0, 1});
    vt.push_back('{5'd11, 0, 32'h80000000, 32'h00000000, 32'h00000001, 0, 1, 0, 1});
    vt.push_back('{5'd9,  0, 32'h00000000, 32'h80000000, 32'h00000001, 0, 1, 0, 1});
    vt.push_back('{5'd12, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1, 0, 0, 1});
    vt.push_back('{5'd13, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 1, 0, 1});
    vt.push_back('{5'd14, 32'h00000001, 0, 0, 32'h3F800000, 1, 0, 0, 33});
    vt.push_back('{5'd14, 32'h80000000, 0, 0, 32'hCF000000, 1, 0, 0, 2});
    vt.push_back('{5'd14, 32'h00000000, 0, 0, 32'h00000000, 1, 0, 0, 1});
    vt.push_back('{5'd14, 32'hFFFFFFFF, 0, 0, 32'hBF800000, 1, 0, 0, 33});
    vt.push_back('{5'd14, 32'h01000001, 0, 0, 32'h4B800000, 1, 0, 0, 9});
    vt.push_back('{5'd14, 32'h01000003, 0, 0, CVT_0103, 1, 0, 0, 9});
    vt.push_back('{5'd31, 0, 32'h3F800000, 0, 32'h00000000, 0, 0, 1, 1});

    // reset state
    reset = 1'b1; start = 1'b0; sel = 5'd0; rs1_int = 0; fs1 = 0; fs2 = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", result, 0);
    chk("reset flags", {28'd0, wr_fp, wr_int, illegal, arith_start}, 0);
    chk("reset arith_op", 32'(arith_op), 0);
    chk("reset arith_a", arith_a, 0);
    chk("reset arith_b", arith_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // table
    foreach (vt[i])
      run_check($sformatf("vec%0d", i), vt[i].sel, vt[i].rs1, vt[i].a, vt[i].b,
                vt[i].res, vt[i].fp, vt[i].wi, vt[i].ill, vt[i].lat);

    // illegal op then mv int->fp issued in its done cycle
    run_check("illegal sel2", 5'd2, 0, 32'h40000000, 32'h40000000, 0, 0, 0, 1, 1);
    run_check("b2b mv", 5'd12, 32'h12345678, 0, 0, 32'h12345678, 1, 0, 0, 1);
    @(negedge clk);

    // reset during cvt aborts
    start = 1'b1; sel = 5'd14; rs1_int = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    reset = 1'b0;
    run_check("post-reset eq", 5'd9, 0, 32'h3F800000, 32'h3F800000, 1, 0, 1, 0, 1);
    @(negedge clk);

    // late arith_done in IDLE is ignored
    force_late = 1'b1;
    seen = 0;
    repeat (2) begin @(negedge clk); if (done || busy) seen = 1; end
    force_late = 1'b0;
    repeat (2) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("late arith_done ignored", 32'(seen), 0);

    // add with core answering 3 cycles after arith_start; a start while busy
    arith_delay = 3; arith_resp = 32'h40400000;
    n0 = n_arith_start;
    bad_busy = 0;
    start = 1'b1; sel = 5'd4; fs1 = 32'h3F800000; fs2 = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      if (!busy) bad_busy++;
      if (lat == 2) begin start = 1'b1; sel = 5'd7; fs1 = 32'h11111111; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("add result", result, 32'h40400000);
    chk("add wr_fp", 32'(wr_fp), 1);
    chk("add latency", 32'(lat), 5);
    chk("add busy held", 32'(bad_busy), 0);
    chk("add arith_start pulses", 32'(n_arith_start - n0), 1);
    chk("add arith_op", 32'(cap_op), 0);
    chk("add arith_a", cap_a, 32'h3F800000);
    chk("add arith_b", cap_b, 32'h40000000);
    @(negedge clk);
    chk("ignored start no done", 32'(done), 0);
    chk("ignored start not busy", 32'(busy), 0);

    // randomized issue against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) s = 5'($urandom_range(0, 31));
      else s = 5'($urandom_range(4, 14));
      case ($urandom_range(0, 5))
        0: r = 32'd0;
        1: r = 32'h80000000;
        2: r = $urandom >> $urandom_range(0, 31);
        3: r = -($urandom >> $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      for (int j = 0; j < 2; j++) begin
        logic [31:0] x;
        case ($urandom_range(0, 9))
          0: x = 32'h00000000;
          1: x = 32'h80000000;
          2: x = 32'h7FC00000;
          3: x = 32'hFF800001;
          4: x = 32'h7F800000;
          5: x = 32'h3F800000;
          6: x = 32'hBF800000;
          default: x = $urandom;
        endcase
        if (j == 0) a = x; else b = x;
      end
      if ($urandom_range(0, 7) == 0) b = a;
      d = $urandom_range(0, 4);
      resp = $urandom;
      arith_delay = d;
      arith_resp = resp;
      n0 = n_arith_start;
      model(s, r, a, b, d, resp, e_res, e_fp, e_wi, e_ill, e_lat);
      run_check($sformatf("rnd%0d sel%0d", k, s), s, r, a, b, e_res, e_fp, e_wi, e_ill, e_lat);
      if (s >= 5'd4 && s <= 5'd6) begin
        chk($sformatf("rnd%0d arith_op", k), 32'(cap_op), 32'(s - 5'd4));
        chk($sformatf("rnd%0d arith_a", k), cap_a, a);
        chk($sformatf("rnd%0d arith_b", k), cap_b, b);
        chk($sformatf("rnd%0d arith_start pulses", k), 32'(n_arith_start - n0), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
